// File: rtl/pe_sequencer.sv
// pe_sequencer: control FSM for the convolution PE datapath.
// Runs one job per accepted start: num_filters filter passes per row,
// num_rows rows, then waits DRAIN_CYCLES for the MAC pipeline and pulses done.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   start                         job start pulse (accepted only when idle)
//   num_rows, num_filters         job dimensions, latched on accepted start
//   av_data, av_filter            IFMap window / filter data available
//   end_of_filter, end_of_row     last tap of filter / early row termination
//   ld_stride, ld_filterSize      configuration load strobes
//   put_data, put_filter          read advance (combinational in RUN)
//   clear_sum, store_buffer       accumulator clear / psum commit
//   next_filter, next_row         filter / row advance
//   busy, done                    job in progress / one-cycle completion pulse
//   stall_cycles                  RUN cycles without a put (PE_SEQ_PERF_EN only)
//
// Optional feature macro: PE_SEQ_PERF_EN adds the saturating stall counter.
module pe_sequencer #(
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned PERF_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_rows,
  input  logic [CNT_WIDTH-1:0] num_filters,
  input  logic                 av_data,
  input  logic                 av_filter,
  input  logic                 end_of_filter,
  input  logic                 end_of_row,
  output logic                 ld_stride,
  output logic                 ld_filterSize,
  output logic                 put_data,
  output logic                 put_filter,
  output logic                 clear_sum,
  output logic                 store_buffer,
  output logic                 next_filter,
  output logic                 next_row,
  output logic                 busy,
`ifdef PE_SEQ_PERF_EN
  output logic [PERF_WIDTH-1:0] stall_cycles,
`endif
  output logic                 done
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Reject nonsensical configurations at elaboration.
  if (DRAIN_CYCLES < 1 || PERF_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("pe_sequencer: DRAIN_CYCLES, PERF_WIDTH and CNT_WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_RUN,
    S_FEND,
    S_REND,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] rows_q, rows_d;
  logic [CNT_WIDTH-1:0] filts_q, filts_d;
  logic [CNT_WIDTH-1:0] filt_cnt_q, filt_cnt_d;
  logic [CNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 fire_c;

  assign fire_c = av_data & av_filter;

  // State and job registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      filts_q    <= '0;
      filt_cnt_q <= '0;
      row_cnt_q  <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      filts_q    <= filts_d;
      filt_cnt_q <= filt_cnt_d;
      row_cnt_q  <= row_cnt_d;
      drain_q    <= drain_d;
    end
  end

  // Next state, counter updates and strobe decode.
  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    filts_d       = filts_q;
    filt_cnt_d    = filt_cnt_q;
    row_cnt_d     = row_cnt_q;
    drain_d       = drain_q;
    ld_stride     = 1'b0;
    ld_filterSize = 1'b0;
    put_data      = 1'b0;
    put_filter    = 1'b0;
    clear_sum     = 1'b0;
    store_buffer  = 1'b0;
    next_filter   = 1'b0;
    next_row      = 1'b0;
    done          = 1'b0;
    busy          = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d     = num_rows;
          filts_d    = num_filters;
          filt_cnt_d = '0;
          row_cnt_d  = '0;
          // An empty job skips straight to completion.
          if (num_rows == '0 || num_filters == '0) state_d = S_DONE;
          else                                     state_d = S_CFG;
        end
      end
      S_CFG: begin
        ld_stride     = 1'b1;
        ld_filterSize = 1'b1;
        clear_sum     = 1'b1;
        state_d       = S_RUN;
      end
      S_RUN: begin
        put_data   = fire_c;
        put_filter = fire_c;
        // end_of_filter takes priority over an early row end.
        if (fire_c && end_of_filter)   state_d = S_FEND;
        else if (fire_c && end_of_row) state_d = S_REND;
      end
      S_FEND: begin
        store_buffer = 1'b1;
        next_filter  = 1'b1;
        clear_sum    = 1'b1;
        filt_cnt_d   = filt_cnt_q + CNT_WIDTH'(1);
        if (filt_cnt_d == filts_q) state_d = S_REND;
        else                       state_d = S_RUN;
      end
      S_REND: begin
        next_row   = 1'b1;
        filt_cnt_d = '0;
        row_cnt_d  = row_cnt_q + CNT_WIDTH'(1);
        if (row_cnt_d == rows_q) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PE_SEQ_PERF_EN
  // Saturating count of RUN cycles that could not fire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_cycles <= '0;
    end else if (state_q == S_RUN && !fire_c && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + PERF_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: directed table of whole jobs,
// hand-written multi-cycle corner sequences, and randomized traffic
// checked against an event-schedule reference model.
`timescale 1ns/1ps
module tb_pe_sequencer;
  localparam int unsigned CW    = 8;
  localparam int unsigned DRAIN = 3;
  localparam int unsigned PW    = 16;

  localparam int EV_CFG  = 0;
  localparam int EV_FEND = 1;
  localparam int EV_REND = 2;
  localparam int EV_DONE = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_rows = '0;
  logic [CW-1:0] num_filters = '0;
  logic          av_data = 1'b0;
  logic          av_filter = 1'b0;
  logic          end_of_filter = 1'b0;
  logic          end_of_row = 1'b0;
  logic          ld_stride, ld_filterSize, put_data, put_filter, clear_sum;
  logic          store_buffer, next_filter, next_row, busy, done;
`ifdef PE_SEQ_PERF_EN
  logic [PW-1:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  pe_sequencer #(.CNT_WIDTH(CW), .DRAIN_CYCLES(DRAIN), .PERF_WIDTH(PW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .num_rows      (num_rows),
    .num_filters   (num_filters),
    .av_data       (av_data),
    .av_filter     (av_filter),
    .end_of_filter (end_of_filter),
    .end_of_row    (end_of_row),
    .ld_stride     (ld_stride),
    .ld_filterSize (ld_filterSize),
    .put_data      (put_data),
    .put_filter    (put_filter),
    .clear_sum     (clear_sum),
    .store_buffer  (store_buffer),
    .next_filter   (next_filter),
    .next_row      (next_row),
    .busy          (busy),
`ifdef PE_SEQ_PERF_EN
    .stall_cycles  (stall_cycles),
`endif
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] outs();
    return {ld_stride, ld_filterSize, put_data, put_filter, clear_sum,
            store_buffer, next_filter, next_row, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int rows;
    int filts;
    int taps;
    int exp_puts;
    int exp_sb;
    int exp_nr;
    int exp_ld;
    int exp_done;
  } vec_t;

  // Run one job with data always available; eof on every taps-th put.
  task automatic run_vec(input vec_t v, input int idx);
    int puts, sb, nf, nr, ld, done_at;
    puts = 0; sb = 0; nf = 0; nr = 0; ld = 0; done_at = -1;
    num_rows = CW'(v.rows);
    num_filters = CW'(v.filts);
    av_data = 1'b1; av_filter = 1'b1; end_of_row = 1'b0; end_of_filter = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 700 && done_at < 0; k++) begin
      end_of_filter = ((puts % v.taps) == v.taps - 1);
      @(negedge clk);
      if (put_data) puts++;
      if (store_buffer) sb++;
      if (next_filter) nf++;
      if (next_row) nr++;
      if (ld_stride) ld++;
      if (done) done_at = k;
      tick();
    end
    check($sformatf("vec%0d_puts", idx), 64'(puts), 64'(v.exp_puts));
    check($sformatf("vec%0d_store_buffer", idx), 64'(sb), 64'(v.exp_sb));
    check($sformatf("vec%0d_next_filter", idx), 64'(nf), 64'(v.exp_sb));
    check($sformatf("vec%0d_next_row", idx), 64'(nr), 64'(v.exp_nr));
    check($sformatf("vec%0d_ld", idx), 64'(ld), 64'(v.exp_ld));
    check($sformatf("vec%0d_done_cycle", idx), 64'(done_at), 64'(v.exp_done));
    @(negedge clk);
    check($sformatf("vec%0d_idle_after", idx), 64'({busy, done}), 64'(0));
    tick();
    end_of_filter = 1'b0;
  endtask

  // Reference model: strobes are scheduled as future events by cycle number.
  logic [3:0] sched [0:63];
  int  cyc;
  bit  m_active, m_running;
  int  m_accept, m_done_cyc, m_rows, m_filts, m_fc, m_rc, m_stall;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) sched[i] = '0;
    m_active = 0; m_running = 0; m_stall = 0;
    m_accept = 0; m_done_cyc = -1;
  endtask

  task automatic post(input int c, input int ev);
    sched[c % 64][ev] = 1'b1;
  endtask

  task automatic finish_job(input int c_done);
    post(c_done, EV_DONE);
    m_done_cyc = c_done;
    m_running = 0;
  endtask

  vec_t tbl [7];

  initial begin
    logic [4:0] exp5;
    bit seen;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("reset_outs", 64'(outs()), 64'(0));
`ifdef PE_SEQ_PERF_EN
    check("reset_stall", 64'(stall_cycles), 64'(0));
`endif
    tick();
    rstn = 1'b1;
    tick();

    // Reset mid-RUN with data available
    num_rows = 8'd2; num_filters = 8'd2;
    av_data = 1'b1; av_filter = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("pre_reset_put", 64'(put_data), 64'(1));
    #1 rstn = 1'b0;
    #1 check("async_reset_outs", 64'(outs()), 64'(0));
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset_idle", 64'(outs()), 64'(0));
      tick();
    end
    av_data = 1'b0; av_filter = 1'b0;

    // Directed job table
    tbl[0] = '{1, 1,   3,   3,   1, 1, 1,  10};
    tbl[1] = '{2, 3,   4,  24,   6, 2, 1,  37};
    tbl[2] = '{1, 0,   2,   0,   0, 0, 0,   1};
    tbl[3] = '{0, 5,   2,   0,   0, 0, 0,   1};
    tbl[4] = '{3, 1,   1,   3,   3, 3, 1,  14};
    tbl[5] = '{1, 2,   2,   4,   2, 1, 1,  12};
    tbl[6] = '{1, 255, 1, 255, 255, 1, 1, 516};
    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // av_filter dropped for 5 RUN cycles
    num_rows = 8'd1; num_filters = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      av_data = 1'b1;
      av_filter = !(k >= 4 && k <= 8);
      end_of_filter = (k == 9);
      @(negedge clk);
      if (k >= 4 && k <= 8) check("stall_no_put", 64'(put_data), 64'(0));
      if (k == 9) check("stall_resume_put", 64'(put_data), 64'(1));
      if (done) begin
        seen = 1;
        check("stall_done_cycle", 64'(k), 64'(15));
`ifdef PE_SEQ_PERF_EN
        check("stall_count_at_done", 64'(stall_cycles), 64'(5));
`endif
      end
      tick();
    end
    if (!seen) check("stall_job_done_seen", 64'(0), 64'(1));
    end_of_filter = 1'b0;
`ifdef PE_SEQ_PERF_EN
    @(negedge clk);
    check("stall_count_holds", 64'(stall_cycles), 64'(5));
    tick();
`endif

    // Early row end resets the filter count; start while busy is ignored
    num_rows = 8'd2; num_filters = 8'd2;
    av_data = 1'b1; av_filter = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      end_of_filter = (k == 2 || k == 6 || k == 8);
      end_of_row = (k == 4);
      start = (k == 4 || k == 11);
      num_rows = (k == 4 || k == 11) ? 8'd0 : 8'd2;
      num_filters = (k == 4 || k == 11) ? 8'd0 : 8'd2;
      exp5 = {(k == 2 || k == 4 || k == 6 || k == 8),
              (k == 3 || k == 7 || k == 9),
              (k == 5 || k == 10),
              (k == 14),
              (k <= 14)};
      @(negedge clk);
      check($sformatf("eor_seq_c%0d", k),
            64'({put_data, store_buffer, next_row, done, busy}), 64'(exp5));
      tick();
    end
    start = 1'b0; end_of_filter = 1'b0; end_of_row = 1'b0;

    // Randomized traffic against the reference model
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    model_reset();
    cyc = 0;
    for (int n = 0; n < 6000; n++) begin
      logic [3:0] ev;
      logic [9:0] exp;
      bit fire, run;
      if ($urandom_range(0, 299) == 0) begin
        rstn = 1'b0;
        #1 check("rand_async_reset", 64'(outs()), 64'(0));
        tick();
        rstn = 1'b1;
        model_reset();
        cyc++;
        continue;
      end
      start = ($urandom_range(0, 7) == 0);
      num_rows = CW'($urandom_range(0, 3));
      num_filters = CW'($urandom_range(0, 3));
      av_data = ($urandom_range(0, 3) != 0);
      av_filter = ($urandom_range(0, 3) != 0);
      end_of_filter = ($urandom_range(0, 9) < 3);
      end_of_row = ($urandom_range(0, 19) < 3);
      @(negedge clk);
      ev = sched[cyc % 64];
      sched[cyc % 64] = '0;
      fire = av_data && av_filter;
      run = m_running && (cyc >= m_accept);
      exp = {ev[EV_CFG], ev[EV_CFG], run && fire, run && fire,
             ev[EV_CFG] || ev[EV_FEND], ev[EV_FEND], ev[EV_FEND],
             ev[EV_REND], m_active, ev[EV_DONE]};
      check("rand_outs", 64'(outs()), 64'(exp));
`ifdef PE_SEQ_PERF_EN
      check("rand_stall", 64'(stall_cycles), 64'(m_stall));
`endif
      if (!m_active && start) begin
        m_active = 1;
        m_rows = int'(num_rows);
        m_filts = int'(num_filters);
        m_fc = 0; m_rc = 0; m_stall = 0;
        if (m_rows == 0 || m_filts == 0) begin
          finish_job(cyc + 1);
        end else begin
          post(cyc + 1, EV_CFG);
          m_accept = cyc + 2;
          m_running = 1;
        end
      end else if (run && fire && end_of_filter) begin
        post(cyc + 1, EV_FEND);
        m_fc++;
        if (m_fc == m_filts) begin
          m_fc = 0;
          m_rc++;
          post(cyc + 2, EV_REND);
          if (m_rc == m_rows) finish_job(cyc + 3 + int'(DRAIN));
          else m_accept = cyc + 3;
        end else begin
          m_accept = cyc + 2;
        end
      end else if (run && fire && end_of_row) begin
        m_fc = 0;
        m_rc++;
        post(cyc + 1, EV_REND);
        if (m_rc == m_rows) finish_job(cyc + 2 + int'(DRAIN));
        else m_accept = cyc + 2;
      end else if (run && !fire && m_stall < (2 ** PW) - 1) begin
        m_stall++;
      end
      if (m_active && cyc == m_done_cyc) m_active = 0;
      tick();
      cyc++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
